// File: rtl/axis_bit_spread_pkg.sv
// ---------------------------------------------------------------------------
// axis_bit_spread_pkg
// Shared spreading-code table and sizing helper for the direct-sequence
// spreader. The code table is the one the bit correlator indexes, so a
// transmitter and a correlator built with the same CODE_NUM use the same
// chip sequence.
//   CORRELATORS  number of codes in the table
//   CORR_LENGTH  chips per code
//   CODE_TABLE   packed table; entry k is CODE_TABLE[k], chip c is bit c
//   cnt_width()  counter width for a 0..n-1 counter (never below 1 bit)
// ---------------------------------------------------------------------------
package axis_bit_spread_pkg;

  localparam int CORRELATORS = 2;
  localparam int CORR_LENGTH = 16;

  // Entry 0 sits in the LSBs of the packed table.
  localparam logic [CORRELATORS-1:0][CORR_LENGTH-1:0] CODE_TABLE = {
    16'h3C5A,
    16'hA5C3
  };

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_bit_spread_if.sv
// ---------------------------------------------------------------------------
// axis_bit_spread_if
// Minimal AXI-stream bundle used for both sides of axis_bit_spread.
//   DATA_W   width of tdata
//   tvalid   beat valid (master -> slave)
//   tready   beat accept (slave -> master)
//   tdata    payload (master -> slave)
//   tlast    end of symbol, present only when AXIS_BIT_SPREAD_TLAST_EN
//            is defined
// Modports: master (drives tvalid/tdata/tlast), slave (drives tready).
// ---------------------------------------------------------------------------
interface axis_bit_spread_if #(
  parameter int DATA_W = 128
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
`ifdef AXIS_BIT_SPREAD_TLAST_EN
  logic              tlast;
`endif

  modport master (
    output tvalid,
    output tdata,
`ifdef AXIS_BIT_SPREAD_TLAST_EN
    output tlast,
`endif
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
`ifdef AXIS_BIT_SPREAD_TLAST_EN
    input  tlast,
`endif
    output tready
  );

endinterface

// File: rtl/axis_bit_spread_counter.sv
// ---------------------------------------------------------------------------
// axis_bit_spread_counter
// Wrapping up-counter LOWER..UPPER with synchronous clear.
//   clk    core clock
//   rst    synchronous active-high reset (count <= LOWER)
//   clr    load LOWER; wins over en
//   en     advance by one, wrapping from UPPER back to LOWER
//   count  current value
// ---------------------------------------------------------------------------
module axis_bit_spread_counter #(
  parameter int LOWER = 0,
  parameter int UPPER = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= W'(LOWER);
    end else if (en) begin
      count <= (count == W'(UPPER)) ? W'(LOWER) : count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_bit_spread.sv
// ---------------------------------------------------------------------------
// axis_bit_spread
// Direct-sequence spreader. Each accepted symbol bit is expanded into the
// +/-AMPLITUDE chip sequence of code CODE_NUM, emitted NUM_PARALLEL chips per
// beat. Chip c = b*NUM_PARALLEL + n goes to lane n of beat b, lane n at
// tdata[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]; chip 0 leaves first in the LSBs.
// Symbol 1 sends the code as-is, symbol 0 sends it inverted.
//
// Ports:
//   clk     core clock
//   rst     synchronous active-high reset
//   s_axis  slave stream, 1-bit symbol (tdata[0])
//   m_axis  master stream, MASTER_WIDTH chip beats, registered
//           (tlast marks the final beat of each symbol when the macro
//           AXIS_BIT_SPREAD_TLAST_EN is defined)
//
// Parameters:
//   NUM_PARALLEL  chips per beat (power of two, divides CORR_LENGTH)
//   MASTER_WIDTH  output width; SAMPLE_WIDTH = MASTER_WIDTH/NUM_PARALLEL
//   AMPLITUDE     chip magnitude, 1 .. 2^(SAMPLE_WIDTH-1)-1
//   CODE_NUM      code table entry
// ---------------------------------------------------------------------------
module axis_bit_spread
  import axis_bit_spread_pkg::*;
#(
  parameter int NUM_PARALLEL = 8,
  parameter int MASTER_WIDTH = 128,
  parameter int AMPLITUDE    = 1,
  parameter int CODE_NUM     = 0
) (
  input  logic clk,
  input  logic rst,
  axis_bit_spread_if.slave  s_axis,
  axis_bit_spread_if.master m_axis
);

  localparam int SAMPLE_WIDTH = MASTER_WIDTH / NUM_PARALLEL;
  localparam int NUM_BEATS    = CORR_LENGTH / NUM_PARALLEL;
  localparam int CNT_W        = cnt_width(NUM_BEATS);

  if ((CORR_LENGTH % NUM_PARALLEL) != 0) begin : g_err_len
    $error("axis_bit_spread: CORR_LENGTH must be a multiple of NUM_PARALLEL");
  end
  if ((NUM_PARALLEL < 1) || ((NUM_PARALLEL & (NUM_PARALLEL - 1)) != 0)) begin : g_err_np
    $error("axis_bit_spread: NUM_PARALLEL must be a power of two");
  end
  if ((MASTER_WIDTH % NUM_PARALLEL) != 0) begin : g_err_mw
    $error("axis_bit_spread: MASTER_WIDTH must be a multiple of NUM_PARALLEL");
  end
  if ((AMPLITUDE < 1) || (AMPLITUDE >= (2 ** (SAMPLE_WIDTH - 1)))) begin : g_err_amp
    $error("axis_bit_spread: AMPLITUDE out of range for SAMPLE_WIDTH");
  end
  if ((CODE_NUM < 0) || (CODE_NUM >= CORRELATORS)) begin : g_err_code
    $error("axis_bit_spread: CODE_NUM outside the code table");
  end

  // The code reshaped as [beat][lane] so the beat counter selects a row.
  localparam logic [NUM_BEATS-1:0][NUM_PARALLEL-1:0] CODE_BEATS = CODE_TABLE[CODE_NUM];

  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_POS = SAMPLE_WIDTH'(AMPLITUDE);
  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_NEG = -AMP_POS;

  function automatic logic signed [SAMPLE_WIDTH-1:0] chip_value(input logic match);
    return match ? AMP_POS : AMP_NEG;
  endfunction

  logic                    busy;
  logic                    sym_reg;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    adv;
  logic                    last_beat;
  logic                    step;
  logic                    sym_hs;
  logic                    s_ready;
  logic [MASTER_WIDTH-1:0] beat_data;

  logic                    vld_p0;
  logic [MASTER_WIDTH-1:0] data_p0;
`ifdef AXIS_BIT_SPREAD_TLAST_EN
  logic                    last_p0;
`endif

  assign adv       = ~vld_p0 | m_axis.tready;
  assign last_beat = (beat_cnt == CNT_W'(NUM_BEATS - 1));
  assign step      = busy & adv;
  // Idle, or about to push the final beat of the current symbol: the next
  // symbol is taken in that same cycle so symbols stream with no bubble.
  assign s_ready   = ~busy | (busy & adv & last_beat);
  assign sym_hs    = s_axis.tvalid & s_ready;

  assign s_axis.tready = s_ready;

  axis_bit_spread_counter #(
    .LOWER (0),
    .UPPER (NUM_BEATS - 1),
    .W     (CNT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (sym_hs),
    .en    (step),
    .count (beat_cnt)
  );

  // Chip generation: chip matches the symbol -> +A, otherwise -A.
  for (genvar n = 0; n < NUM_PARALLEL; n++) begin : g_lane
    assign beat_data[n*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
      chip_value(CODE_BEATS[beat_cnt][n] ~^ sym_reg);
  end

  always_ff @(posedge clk) begin
    if (sym_hs) begin
      sym_reg <= s_axis.tdata[0];
    end
  end

  // Stage p0: output register; holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      vld_p0  <= 1'b0;
      data_p0 <= '0;
`ifdef AXIS_BIT_SPREAD_TLAST_EN
      last_p0 <= 1'b0;
`endif
    end else begin
      if (step) begin
        vld_p0  <= 1'b1;
        data_p0 <= beat_data;
`ifdef AXIS_BIT_SPREAD_TLAST_EN
        last_p0 <= last_beat;
`endif
        if (last_beat) begin
          busy <= 1'b0;
        end
      end else if (adv) begin
        vld_p0 <= 1'b0;
      end
      // A new symbol overrides the end-of-symbol clear above.
      if (sym_hs) begin
        busy <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid = vld_p0;
  assign m_axis.tdata  = data_p0;
`ifdef AXIS_BIT_SPREAD_TLAST_EN
  assign m_axis.tlast  = last_p0;
`endif

endmodule
